// File: rtl/mem_access_stage.sv
// Memory-access stage: pass-through of ALU results, or a multi-cycle load/store
// over a req/ack port with timeout abort, feeding a registered write-back bundle.
module mem_access_stage #(
  parameter int DATA_W  = 16,
  parameter int RD_W    = 3,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              reg_write_in,
  input  logic [RD_W-1:0]   rd_in,
  input  logic              flag_zero_in,
  input  logic              flag_negative_in,
  input  logic              flush,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [RD_W-1:0]   wb_rd,
  output logic              wb_reg_write,
  output logic              wb_flag_zero,
  output logic              wb_flag_negative,
  output logic              bus_error,
  output logic              busy_dbg
);
  // Handshake: the stage owns mem_req while BUSY and holds address/data/we stable
  // until the single-cycle mem_ack; upstream must hold its bundle while stall=1.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              rw_q, rw_d;
  logic              fz_q, fz_d;
  logic              fn_q, fn_d;
  logic              flushed_q, flushed_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
  logic              wb_rw_q, wb_rw_d;
  logic              wb_fz_q, wb_fz_d;
  logic              wb_fn_q, wb_fn_d;
  logic              berr_q, berr_d;
  logic              drop_wb;

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    rw_d       = rw_q;
    fz_d       = fz_q;
    fn_d       = fn_q;
    flushed_d  = flushed_q;
    cnt_d      = cnt_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_rw_d    = wb_rw_q;
    wb_fz_d    = wb_fz_q;
    wb_fn_d    = wb_fn_q;
    berr_d     = 1'b0;
    stall      = 1'b0;
    drop_wb    = flushed_q | flush;
    case (state_q)
      IDLE: begin
        if (valid_in && !flush) begin
          if (mem_read || mem_write) begin
            stall     = 1'b1;
            state_d   = BUSY;
            we_d      = mem_write;
            addr_d    = alu_result;
            wdata_d   = store_data;
            rd_d      = rd_in;
            rw_d      = reg_write_in;
            fz_d      = flag_zero_in;
            fn_d      = flag_negative_in;
            flushed_d = 1'b0;
            cnt_d     = '0;
          end else begin
            wb_valid_d = 1'b1;
            wb_data_d  = alu_result;
            wb_rd_d    = rd_in;
            wb_rw_d    = reg_write_in;
            wb_fz_d    = flag_zero_in;
            wb_fn_d    = flag_negative_in;
          end
        end
      end
      BUSY: begin
        stall = !mem_ack;
        if (flush) flushed_d = 1'b1;
        if (mem_ack) begin
          state_d = IDLE;
          if (!drop_wb) begin
            wb_valid_d = 1'b1;
            wb_data_d  = we_q ? '0 : mem_rdata;
            wb_rw_d    = we_q ? 1'b0 : rw_q;
            wb_rd_d    = rd_q;
            wb_fz_d    = fz_q;
            wb_fn_d    = fn_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          // Abort on the edge where the counter would reach TIMEOUT.
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            berr_d  = 1'b1;
            if (!drop_wb) begin
              wb_valid_d = 1'b1;
              wb_data_d  = '0;
              wb_rw_d    = 1'b0;
              wb_rd_d    = rd_q;
              wb_fz_d    = fz_q;
              wb_fn_d    = fn_q;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      rw_q       <= 1'b0;
      fz_q       <= 1'b0;
      fn_q       <= 1'b0;
      flushed_q  <= 1'b0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_rw_q    <= 1'b0;
      wb_fz_q    <= 1'b0;
      wb_fn_q    <= 1'b0;
      berr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      rw_q       <= rw_d;
      fz_q       <= fz_d;
      fn_q       <= fn_d;
      flushed_q  <= flushed_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_rw_q    <= wb_rw_d;
      wb_fz_q    <= wb_fz_d;
      wb_fn_q    <= wb_fn_d;
      berr_q     <= berr_d;
    end
  end

  assign mem_req          = (state_q == BUSY);
  assign busy_dbg         = (state_q == BUSY);
  assign mem_we           = we_q;
  assign mem_addr         = addr_q;
  assign mem_wdata        = wdata_q;
  assign wb_valid         = wb_valid_q;
  assign wb_data          = wb_data_q;
  assign wb_rd            = wb_rd_q;
  assign wb_reg_write     = wb_rw_q;
  assign wb_flag_zero     = wb_fz_q;
  assign wb_flag_negative = wb_fn_q;
  assign bus_error        = berr_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_access_stage;
  localparam int DATA_W  = 16;
  localparam int RD_W    = 3;
  localparam int TIMEOUT = 15;
  localparam int WB_W    = DATA_W + RD_W + 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              valid_in = 1'b0;
  logic [DATA_W-1:0] alu_result = '0;
  logic [DATA_W-1:0] store_data = '0;
  logic              mem_read = 1'b0;
  logic              mem_write = 1'b0;
  logic              reg_write_in = 1'b0;
  logic [RD_W-1:0]   rd_in = '0;
  logic              flag_zero_in = 1'b0;
  logic              flag_negative_in = 1'b0;
  logic              flush = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ack = 1'b0;
  logic              stall, mem_req, mem_we, wb_valid, wb_reg_write;
  logic              wb_flag_zero, wb_flag_negative, bus_error, busy_dbg;
  logic [DATA_W-1:0] mem_addr, mem_wdata, wb_data;
  logic [RD_W-1:0]   wb_rd;

  int total = 0;
  int bad = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mem_access_stage #(.DATA_W(DATA_W), .RD_W(RD_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .alu_result(alu_result),
    .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write_in(reg_write_in), .rd_in(rd_in), .flag_zero_in(flag_zero_in),
    .flag_negative_in(flag_negative_in), .flush(flush), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_flag_zero(wb_flag_zero),
    .wb_flag_negative(wb_flag_negative), .bus_error(bus_error), .busy_dbg(busy_dbg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic              m_busy = 1'b0;
  int                m_waited = 0;
  logic              m_dropped = 1'b0;
  logic              m_berr = 1'b0;
  logic              t_we = 1'b0;
  logic [DATA_W-1:0] t_addr = '0, t_wdata = '0;
  logic [RD_W-1:0]   t_rd = '0;
  logic              t_rw = 1'b0, t_fz = 1'b0, t_fn = 1'b0;
  logic [WB_W-1:0]   m_hold = '0;
  logic [WB_W-1:0]   exp_q[$];

  function automatic void push_wb(input logic [DATA_W-1:0] d, input logic [RD_W-1:0] r,
                                  input logic w, input logic z, input logic n);
    m_hold = {d, r, w, z, n};
    exp_q.push_back(m_hold);
  endfunction

  always @(posedge clk) begin
    m_berr = 1'b0;
    if (reset) begin
      m_busy = 1'b0;
      m_waited = 0;
      m_hold = '0;
      t_we = 1'b0;
      t_addr = '0;
      t_wdata = '0;
      exp_q.delete();
    end else if (!m_busy) begin
      if (valid_in && !flush) begin
        if (mem_read || mem_write) begin
          m_busy = 1'b1;
          m_waited = 0;
          m_dropped = 1'b0;
          t_we = mem_write;
          t_addr = alu_result;
          t_wdata = store_data;
          t_rd = rd_in;
          t_rw = reg_write_in;
          t_fz = flag_zero_in;
          t_fn = flag_negative_in;
        end else begin
          push_wb(alu_result, rd_in, reg_write_in, flag_zero_in, flag_negative_in);
        end
      end
    end else begin
      if (flush) m_dropped = 1'b1;
      if (mem_ack) begin
        m_busy = 1'b0;
        if (!m_dropped) push_wb(t_we ? '0 : mem_rdata, t_rd, t_we ? 1'b0 : t_rw, t_fz, t_fn);
      end else begin
        m_waited++;
        if (m_waited == TIMEOUT) begin
          m_busy = 1'b0;
          m_berr = 1'b1;
          if (!m_dropped) push_wb('0, t_rd, 1'b0, t_fz, t_fn);
        end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    logic [WB_W-1:0] act;
    logic [WB_W-1:0] e;
    logic            exp_stall;
    act = {wb_data, wb_rd, wb_reg_write, wb_flag_zero, wb_flag_negative};
    if (wb_valid) begin
      if (exp_q.size() == 0) chk("wb_spurious", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("wb_bundle", act, e);
      end
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("wb_missing", 0, 1);
    end
    chk("wb_hold", act, m_hold);
    chk("bus_error", bus_error, m_berr);
    chk("mem_req", mem_req, m_busy);
    chk("busy_dbg", busy_dbg, m_busy);
    if (m_busy) begin
      chk("mem_we", mem_we, t_we);
      chk("mem_addr", mem_addr, t_addr);
      chk("mem_wdata", mem_wdata, t_wdata);
    end
    exp_stall = m_busy ? !mem_ack : (valid_in && !flush && (mem_read || mem_write));
    chk("stall", stall, exp_stall);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0; reg_write_in = 1'b0;
    alu_result = '0; store_data = '0; rd_in = '0; flag_zero_in = 1'b0;
    flag_negative_in = 1'b0; flush = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic drive_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] sd,
                          input logic rdb, input logic wrb, input logic rw,
                          input logic [RD_W-1:0] rd);
    valid_in = 1'b1; alu_result = a; store_data = sd; mem_read = rdb;
    mem_write = wrb; reg_write_in = rw; rd_in = rd;
    flag_zero_in = 1'b0; flag_negative_in = 1'b0;
  endtask

  int n;
  logic found;
  int plan_delay = 1;

  initial begin
    idle_inputs();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_wb_data", wb_data, 0);

    // pass-through
    drive_op(16'h1234, 16'h0, 1'b0, 1'b0, 1'b1, 3'd3);
    #1 chk("pt_stall", stall, 0);
    step();
    idle_inputs();
    chk("pt_wb_valid", wb_valid, 1);
    chk("pt_wb_data", wb_data, 16'h1234);
    chk("pt_wb_rd", wb_rd, 3);

    // load, ack in third BUSY cycle
    drive_op(16'h0040, 16'h0, 1'b1, 1'b0, 1'b1, 3'd5);
    #1 chk("ld_stall_idle", stall, 1);
    step();
    idle_inputs();
    chk("ld_addr", mem_addr, 16'h0040);
    chk("ld_we", mem_we, 0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (mem_req) n++;
      if (i == 2) begin
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        #1 chk("ld_stall_ack", stall, 0);
      end else chk("ld_stall_busy", stall, 1);
      step();
    end
    mem_ack = 1'b0;
    chk("ld_req_cycles", n, 3);
    chk("ld_wb_valid", wb_valid, 1);
    chk("ld_wb_data", wb_data, 16'hBEEF);
    chk("ld_req_drop", mem_req, 0);

    // store with immediate ack, then ALU op held across the ack edge
    drive_op(16'h0010, 16'hA5A5, 1'b0, 1'b1, 1'b1, 3'd2);
    step();
    chk("st_we", mem_we, 1);
    chk("st_wdata", mem_wdata, 16'hA5A5);
    mem_ack = 1'b1;
    drive_op(16'h0007, 16'h0, 1'b0, 1'b0, 1'b1, 3'd1);
    step();
    mem_ack = 1'b0;
    chk("st_wb_valid", wb_valid, 1);
    chk("st_wb_rw", wb_reg_write, 0);
    chk("st_wb_data", wb_data, 0);
    step();
    idle_inputs();
    chk("alu_wb_valid", wb_valid, 1);
    chk("alu_wb_data", wb_data, 16'h0007);
    step();
    chk("alu_no_dup", wb_valid, 0);

    // timeout
    drive_op(16'h0100, 16'h0, 1'b1, 1'b0, 1'b1, 3'd4);
    step();
    idle_inputs();
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus_error) found = 1'b1;
      else begin
        if (mem_req) n++;
        step();
      end
    end
    chk("to_seen", found, 1);
    chk("to_cycles", n, TIMEOUT);
    chk("to_wb_valid", wb_valid, 1);
    chk("to_wb_data", wb_data, 0);
    drive_op(16'h0055, 16'h0, 1'b0, 1'b0, 1'b1, 3'd6);
    step();
    idle_inputs();
    chk("to_next_wb", wb_data, 16'h0055);

    // flush in BUSY cycle 2, ack in cycle 4
    drive_op(16'h0200, 16'h0, 1'b1, 1'b0, 1'b1, 3'd7);
    step();
    idle_inputs();
    for (int i = 1; i <= 4; i++) begin
      flush = (i == 2);
      mem_ack = (i == 4);
      mem_rdata = 16'h1111;
      step();
    end
    idle_inputs();
    chk("fl_busy_wb", wb_valid, 0);
    chk("fl_busy_req", mem_req, 0);
    drive_op(16'h0333, 16'h0, 1'b0, 1'b0, 1'b1, 3'd1);
    flush = 1'b1;
    step();
    idle_inputs();
    chk("fl_idle_wb", wb_valid, 0);

    // reset mid-BUSY, then a late ack
    drive_op(16'h0300, 16'h0, 1'b1, 1'b0, 1'b1, 3'd2);
    step();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    mem_ack = 1'b1;
    chk("rb_req", mem_req, 0);
    chk("rb_wb_data", wb_data, 0);
    step();
    mem_ack = 1'b0;
    chk("rb_late_wb", wb_valid, 0);
    chk("rb_late_req", mem_req, 0);

    // both read and write set
    drive_op(16'h0400, 16'h5A5A, 1'b1, 1'b1, 1'b1, 3'd3);
    step();
    idle_inputs();
    chk("both_we", mem_we, 1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("both_wb_rw", wb_reg_write, 0);

    // randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset = ($urandom_range(0, 299) == 0);
      valid_in = ($urandom_range(0, 3) != 0);
      alu_result = DATA_W'($urandom);
      store_data = DATA_W'($urandom);
      mem_read = ($urandom_range(0, 2) == 0);
      mem_write = ($urandom_range(0, 3) == 0);
      reg_write_in = $urandom_range(0, 1);
      rd_in = RD_W'($urandom);
      flag_zero_in = $urandom_range(0, 1);
      flag_negative_in = $urandom_range(0, 1);
      mem_rdata = DATA_W'($urandom);
      if (m_busy) begin
        flush = ($urandom_range(0, 19) == 0);
        mem_ack = (m_waited + 1 == plan_delay);
      end else begin
        flush = ($urandom_range(0, 9) == 0);
        mem_ack = ($urandom_range(0, 9) == 0);
        plan_delay = $urandom_range(1, TIMEOUT + 3);
      end
      step();
    end
    reset = 1'b0;
    idle_inputs();
    step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
